instr_encode_loader: RTL

//  Encodes RV32I instructions from field form (format, opcode, rd, rs1, rs2, fn3, fn7, imm) into 32-bit words.

---
 rtl/instr_encode_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_encode_loader.sv
// RV32I field-to-word encoder that streams encoded words into instruction memory and
// holds the CPU in reset until the program is loaded. Optional macro: ENC_RANGE_CHECK_EN.
module instr_encode_loader #(
  parameter int D_WIDTH   = 32,
  parameter int A_WIDTH   = 12,
  parameter int BASE_ADDR = 0,
  parameter int MAX_INSTR = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [2:0]                         fmt,
  input  logic [6:0]                         opcode,
  input  logic [4:0]                         rd,
  input  logic [4:0]                         rs1,
  input  logic [4:0]                         rs2,
  input  logic [2:0]                         fn3,
  input  logic [6:0]                         fn7,
  input  logic [31:0]                        imm,
  input  logic                               last,
  input  logic                               reload,
  output logic                               mem_we,
  output logic [A_WIDTH-1:0]                 mem_addr,
  output logic [D_WIDTH-1:0]                 mem_wdata,
  output logic [$clog2(MAX_INSTR+1)-1:0]     count,
  output logic                               cpu_hold,
  output logic                               done,
  output logic                               err
);

  localparam int C_WIDTH = $clog2(MAX_INSTR + 1);
  localparam logic [D_WIDTH-1:0] NOP_WORD = D_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_LOAD, S_DONE, S_FAIL} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic                 r_memWe;
  logic [A_WIDTH-1:0]   r_memAddr;
  logic [D_WIDTH-1:0]   r_memWdata;
  logic [C_WIDTH-1:0]   r_count;
  logic                 r_pendDone;
  logic                 r_pendFail;
  logic                 r_encErr;
  logic                 w_accept;
  logic                 w_failState;
  logic                 w_violation;
  logic [D_WIDTH-1:0]   w_word;
  logic [D_WIDTH-1:0]   w_wordOut;
  logic [31:0]          w_addrFull;

  always_comb begin
    w_word = NOP_WORD;
    case (fmt)
      3'd0: w_word = {fn7, rs2, rs1, fn3, rd, opcode};
      3'd1: w_word = {imm[11:0], rs1, fn3, rd, opcode};
      3'd2: w_word = {imm[11:5], rs2, rs1, fn3, imm[4:0], opcode};
      3'd3: w_word = {imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], opcode};
      3'd4: w_word = {imm[31:12], rd, opcode};
      3'd5: w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_word = NOP_WORD;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Immediates that do not fit the format's signed field (or are misaligned) become a NOP.
  always_comb begin
    w_violation = 1'b0;
    case (fmt)
      3'd0:       w_violation = 1'b0;
      3'd1, 3'd2: w_violation = (imm[31:11] != {21{imm[11]}});
      3'd3:       w_violation = (imm[31:12] != {20{imm[12]}}) || imm[0];
      3'd4:       w_violation = (imm[11:0] != 12'd0);
      3'd5:       w_violation = (imm[31:20] != {12{imm[20]}}) || imm[0];
      default:    w_violation = 1'b1;
    endcase
  end
  assign w_wordOut = w_violation ? NOP_WORD : w_word;
`else
  assign w_violation = 1'b0;
  assign w_wordOut   = w_word;
`endif

  assign w_accept   = in_valid && in_ready;
  assign w_addrFull = 32'(BASE_ADDR) + (32'(r_count) << 2);

  // Done/fail are deferred one cycle via r_pend* so the CPU never sees done before the last write.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    cpu_hold    = 1'b1;
    done        = 1'b0;
    w_failState = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = !r_pendDone && !r_pendFail && (r_count < C_WIDTH'(MAX_INSTR));
        if (r_pendDone)      w_nextState = S_DONE;
        else if (r_pendFail) w_nextState = S_FAIL;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (reload) w_nextState = S_LOAD;
      end
      S_FAIL: w_failState = 1'b1;
      default: w_nextState = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_memWe    <= 1'b0;
      r_memAddr  <= A_WIDTH'(BASE_ADDR);
      r_memWdata <= '0;
      r_count    <= '0;
      r_pendDone <= 1'b0;
      r_pendFail <= 1'b0;
      r_encErr   <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_memWe    <= w_accept;
      r_pendDone <= w_accept && last;
      r_pendFail <= w_accept && !last && (r_count == C_WIDTH'(MAX_INSTR - 1));
      if (w_accept) begin
        r_memAddr  <= w_addrFull[A_WIDTH-1:0];
        r_memWdata <= w_wordOut;
        r_count    <= r_count + C_WIDTH'(1);
        r_encErr   <= r_encErr || w_violation;
      end else if (r_state == S_DONE && reload) begin
        r_count   <= '0;
        r_memAddr <= A_WIDTH'(BASE_ADDR);
      end
    end
  end

  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign count     = r_count;
  assign err       = w_failState || r_encErr;

endmodule
